// File: rtl/pulse_hold_pkg.sv
// Shared game-input package: state encoding for the pulse stretcher, exposed so
// debug/HUD logic can decode it.
package pulse_hold_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        COOL = 2'd2
    } ph_state_e;

endpackage

// File: rtl/pulse_hold.sv
// Pulse-to-level converter: stretches a trigger into a HOLD_CYCLES-wide level,
// then ignores triggers for COOLDOWN_CYCLES before re-arming.
module pulse_hold
    import pulse_hold_pkg::*;
#(
    parameter  int HOLD_CYCLES     = 8,
    parameter  int COOLDOWN_CYCLES = 4,
    parameter  int RETRIGGER       = 0,
    localparam int MAXC            = (HOLD_CYCLES > COOLDOWN_CYCLES) ? HOLD_CYCLES : COOLDOWN_CYCLES,
    localparam int CW              = $clog2(MAXC + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          trig,
    output logic          level,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] remaining
);

    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] COOL_LD = (COOLDOWN_CYCLES > 0) ? CW'(COOLDOWN_CYCLES - 1) : '0;

    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("pulse_hold: HOLD_CYCLES must be >= 1");
    end

    ph_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          busy_q;
    logic          done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (trig) begin
                        state_q <= HOLD;
                        cnt_q   <= HOLD_LD;
                        level_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                HOLD: begin
                    // Retrigger outranks expiry, so a trigger on the cnt=0 edge extends the hold.
                    if ((RETRIGGER != 0) && trig) begin
                        cnt_q <= HOLD_LD;
                    end else if (cnt_q == '0) begin
                        level_q <= 1'b0;
                        done_q  <= 1'b1;
                        if (COOLDOWN_CYCLES > 0) begin
                            state_q <= COOL;
                            cnt_q   <= COOL_LD;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                COOL: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign level     = level_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign remaining = (state_q == HOLD) ? (cnt_q + CW'(1)) : '0;

endmodule

// File: tb/tb_pulse_hold.sv
// Directed bench for pulse_hold: three instances cover the default config,
// retrigger mode and zero cooldown, all driven from the same trig/reset.
module tb_pulse_hold;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       trig = 1'b0;

    logic       lv0, bz0, dn0;
    logic [3:0] rm0;
    logic       lv1, bz1, dn1;
    logic [3:0] rm1;
    logic       lv2, bz2, dn2;
    logic [3:0] rm2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pulse_hold #(.HOLD_CYCLES(8), .COOLDOWN_CYCLES(4), .RETRIGGER(0)) u_def (
        .clk(clk), .reset(reset), .trig(trig),
        .level(lv0), .busy(bz0), .done(dn0), .remaining(rm0));

    pulse_hold #(.HOLD_CYCLES(8), .COOLDOWN_CYCLES(4), .RETRIGGER(1)) u_rtg (
        .clk(clk), .reset(reset), .trig(trig),
        .level(lv1), .busy(bz1), .done(dn1), .remaining(rm1));

    pulse_hold #(.HOLD_CYCLES(8), .COOLDOWN_CYCLES(0), .RETRIGGER(0)) u_nocool (
        .clk(clk), .reset(reset), .trig(trig),
        .level(lv2), .busy(bz2), .done(dn2), .remaining(rm2));

    // Advance across one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        trig  = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] got;
        reset = 1'b1;
        trig  = 1'b0;
        tick();
        got = {lv0, bz0, dn0, rm0};
        checks++;
        if (got !== 7'b0) begin
            failures++;
            $display("FAIL reset_state def got=%b exp=%b", got, 7'b0);
        end
        got = {lv2, bz2, dn2, rm2};
        checks++;
        if (got !== 7'b0) begin
            failures++;
            $display("FAIL reset_state nocool got=%b exp=%b", got, 7'b0);
        end
        // Start a hold, then reset with trig also high: trig must be dropped.
        reset = 1'b0;
        trig  = 1'b1;
        tick();
        got = {lv1, bz1, dn1, rm1};
        checks++;
        if (got !== {1'b1, 1'b1, 1'b0, 4'd8}) begin
            failures++;
            $display("FAIL reset_pre_accept got=%b exp=%b", got, {1'b1, 1'b1, 1'b0, 4'd8});
        end
        reset = 1'b1;
        trig  = 1'b1;
        tick();
        got = {lv1, bz1, dn1, rm1};
        checks++;
        if (got !== 7'b0) begin
            failures++;
            $display("FAIL reset_with_trig got=%b exp=%b", got, 7'b0);
        end
        reset = 1'b0;
        trig  = 1'b0;
        tick();
        got = {lv1, bz1, dn1, rm1};
        checks++;
        if (got !== 7'b0) begin
            failures++;
            $display("FAIL reset_after got=%b exp=%b", got, 7'b0);
        end
    endtask

    task automatic test_basic();
        logic [6:0] got, exp;
        logic       l, b, d;
        logic [3:0] r;
        do_reset();
        for (int e = 0; e <= 15; e++) begin
            int c;
            trig = (e == 0);
            tick();
            c = e + 1;
            l = (c >= 1 && c <= 8);
            d = (c == 9);
            b = (c <= 12);
            r = l ? 4'(9 - c) : 4'd0;
            exp = {l, b, d, r};
            got = {lv0, bz0, dn0, rm0};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL basic cycle=%0d got=%b exp=%b", c, got, exp);
            end
        end
    endtask

    task automatic test_ignore();
        logic [6:0] got, exp;
        logic       l, b, d;
        logic [3:0] r;
        do_reset();
        for (int e = 0; e <= 26; e++) begin
            int c;
            trig = (e == 0 || e == 3 || e == 10 || e == 13);
            tick();
            c = e + 1;
            l = (c >= 1 && c <= 8) || (c >= 14 && c <= 21);
            d = (c == 9) || (c == 22);
            b = (c <= 12) || (c >= 14 && c <= 25);
            r = (c <= 8) ? 4'(9 - c) : (c >= 14 && c <= 21) ? 4'(22 - c) : 4'd0;
            exp = {l, b, d, r};
            got = {lv0, bz0, dn0, rm0};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL ignore cycle=%0d got=%b exp=%b", c, got, exp);
            end
        end
    endtask

    task automatic test_retrigger();
        logic [6:0] got, exp;
        logic       l, b, d;
        logic [3:0] r;
        do_reset();
        for (int e = 0; e <= 19; e++) begin
            int c;
            trig = (e == 0 || e == 5);
            tick();
            c = e + 1;
            l = (c >= 1 && c <= 13);
            d = (c == 14);
            b = (c <= 17);
            r = (c <= 5) ? 4'(9 - c) : (c <= 13) ? 4'(14 - c) : 4'd0;
            exp = {l, b, d, r};
            got = {lv1, bz1, dn1, rm1};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL retrigger cycle=%0d got=%b exp=%b", c, got, exp);
            end
        end
    endtask

    task automatic test_retrig_at_expiry();
        logic [6:0] got, exp;
        logic       l, b, d;
        logic [3:0] r;
        do_reset();
        for (int e = 0; e <= 21; e++) begin
            int c;
            trig = (e == 0 || e == 8);
            tick();
            c = e + 1;
            l = (c >= 1 && c <= 16);
            d = (c == 17);
            b = (c <= 20);
            r = (c <= 8) ? 4'(9 - c) : (c <= 16) ? 4'(17 - c) : 4'd0;
            exp = {l, b, d, r};
            got = {lv1, bz1, dn1, rm1};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL retrig_expiry cycle=%0d got=%b exp=%b", c, got, exp);
            end
        end
    endtask

    task automatic test_nocool_held();
        logic [6:0] got, exp;
        logic       l, b, d;
        logic [3:0] r;
        do_reset();
        trig = 1'b1;
        for (int e = 0; e <= 29; e++) begin
            int c, ph;
            tick();
            c  = e + 1;
            ph = (c - 1) % 9;
            l = (ph < 8);
            d = (ph == 8);
            b = l;
            r = l ? 4'(8 - ph) : 4'd0;
            exp = {l, b, d, r};
            got = {lv2, bz2, dn2, rm2};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL nocool_held cycle=%0d got=%b exp=%b", c, got, exp);
            end
        end
        trig = 1'b0;
    endtask

    task automatic test_reset_mid_hold();
        logic [6:0] got, exp;
        logic       l, b, d;
        logic [3:0] r;
        do_reset();
        for (int e = 0; e <= 15; e++) begin
            int c;
            trig  = (e == 0 || e == 6);
            reset = (e == 4);
            tick();
            c = e + 1;
            if (c <= 4) begin
                l = 1'b1; b = 1'b1; d = 1'b0; r = 4'(9 - c);
            end else begin
                l = (c >= 7 && c <= 14);
                d = (c == 15);
                b = (c >= 7);
                r = l ? 4'(15 - c) : 4'd0;
            end
            exp = {l, b, d, r};
            got = {lv0, bz0, dn0, rm0};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL reset_mid cycle=%0d got=%b exp=%b", c, got, exp);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignore();
        test_retrigger();
        test_retrig_at_expiry();
        test_nocool_held();
        test_reset_mid_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pulse_hold.md
# pulse_hold

Pulse-to-level converter for the game-input path. It turns a single-cycle trigger pulse into an output level held high for a fixed number of cycles, then enforces an optional cooldown before it accepts another trigger. Typical uses are jump duration, invulnerability windows and flash effects. It sits downstream of the button edge-detection logic and upstream of the player/physics FSMs.

## Interface
- HOLD_CYCLES, 8: cycles `level` stays high per accepted trigger; must be ≥ 1.
- COOLDOWN_CYCLES, 4: cycles after the hold during which triggers are ignored; 0 allowed.
- RETRIGGER, 0: 1 = a trigger during the hold reloads the hold count; 0 = such a trigger is ignored.
- CW, $clog2(max(HOLD_CYCLES, COOLDOWN_CYCLES)+1): counter width (derived, not overridden).
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- trig, input, 1: trigger, sampled every posedge; normally a 1-cycle pulse, but a held level is legal.
- level, output, 1: stretched output, registered.
- busy, output, 1: high during hold and cooldown, registered.
- done, output, 1: 1-cycle pulse on the first cycle after the hold ends, registered.
- remaining, output, CW: hold cycles left including the current one while `level`=1; otherwise 0.

## Operation
- States are IDLE, HOLD and COOL. There is one down-counter `cnt`, CW bits wide.
- Reset: state=IDLE, cnt=0, level=0, busy=0, done=0, remaining=0.
- **IDLE**, edge with trig=1:
  - state←HOLD, cnt←HOLD_CYCLES-1, level←1, busy←1.
  - trig=0: no change.
- **HOLD**, checks in priority order:
  1. RETRIGGER=1 and trig=1: cnt←HOLD_CYCLES-1, level stays 1. This applies even when cnt=0, so retrigger beats expiry.
  2. cnt=0: level←0 and done←1.
     - COOLDOWN_CYCLES>0: state←COOL, cnt←COOLDOWN_CYCLES-1, busy stays 1.
     - COOLDOWN_CYCLES=0: state←IDLE, busy←0.
  3. Otherwise: cnt←cnt-1.
- **COOL**: trig is ignored.
  - cnt=0: state←IDLE, busy←0.
  - Otherwise: cnt←cnt-1.
- Leaving HOLD never accepts a new trigger on the same edge. A trigger is accepted only on an edge where state is already IDLE.
- done is high exactly one cycle per completed hold. done is not asserted when reset aborts a hold.
- remaining = cnt+1 in HOLD, else 0. It is combinational from registered state, so it has no extra latency.
- The counter never wraps: every decrement is guarded by cnt≠0.

## Timing
- Accepting edge E: level is high for cycles E+1 through E+HOLD_CYCLES, exactly HOLD_CYCLES cycles. busy rises with level.
- done is high in cycle E+HOLD_CYCLES+1. level is 0 in that same cycle.
- busy falls at edge E+HOLD_CYCLES+COOLDOWN_CYCLES, so it is low from cycle E+HOLD_CYCLES+COOLDOWN_CYCLES+1.
- Earliest next accepting edge is E+HOLD_CYCLES+COOLDOWN_CYCLES+1.
- Retrigger accepted at edge R: level is held through cycle R+HOLD_CYCLES.
- trig held continuously with RETRIGGER=0: a new hold starts every HOLD_CYCLES+COOLDOWN_CYCLES+1 cycles.
- trig held continuously with RETRIGGER=1: level stays high indefinitely.
- Reset asserted mid-HOLD or mid-COOL: all outputs read the reset values in the cycle after that edge. A trig present on the same edge as reset is dropped.

## Structure
- Shared game package holds the state typedef (IDLE, HOLD, COOL) so that debug/HUD logic can decode state.
- CW is computed locally from the parameters; no package constant is needed.
- Single module. The counter stays inline; no sub-module is warranted.
- Elaboration-time assertion: HOLD_CYCLES ≥ 1.

## Test plan
- HOLD=8, COOL=4, RETRIGGER=0, trig pulse at edge 0:
  - level=1 in cycles 1–8.
  - done=1 in cycle 9 only.
  - busy=1 in cycles 1–12, busy=0 from cycle 13.
  - remaining reads 8,7,…,1 over cycles 1–8.
- Same config, trig pulses at edges 3 and 10: both ignored, level waveform unchanged. A trig at edge 13 is accepted, with level=1 in cycles 14–21.
- RETRIGGER=1, trig at edges 0 and 5: level=1 in cycles 1–13, single done in cycle 14, remaining reloads to 8 in cycle 6.
- COOL=0, trig held high continuously: level pattern is 8 high, 1 low, repeating; done coincides with each low cycle.
- Reset at edge 4 during a hold started at edge 0: level=busy=remaining=0 from cycle 5, no done pulse, and a trig at edge 6 is accepted normally.
- RETRIGGER=1, trig exactly at the cnt=0 edge (edge 8 after acceptance at 0): retrigger wins, level stays high through cycle 16, and no done pulse appears in cycle 9.
